// File: rtl/mem.sv
// Memory stage: forwards ALU results and turns loads/stores into byte-wide memory accesses.
// Define MEM_ALIGN_CHECK_EN to report misaligned halfword/word accesses on err_o instead of performing them.
module mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  op_i,
    input  logic [31:0] mem_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_din_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        err_o
);

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_SAVE = 7'b0100011;

    localparam logic [4:0] OP_LB  = 5'd0;
    localparam logic [4:0] OP_LH  = 5'd1;
    localparam logic [4:0] OP_LW  = 5'd2;
    localparam logic [4:0] OP_LBU = 5'd4;
    localparam logic [4:0] OP_LHU = 5'd5;
    localparam logic [4:0] OP_SB  = 5'd8;
    localparam logic [4:0] OP_SH  = 5'd9;
    localparam logic [4:0] OP_SW  = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [2:0] byte_count(input logic [4:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: byte_count = 3'd1;
            OP_LH, OP_LHU, OP_SH: byte_count = 3'd2;
            OP_LW, OP_SW:         byte_count = 3'd4;
            default:              byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [4:0] op, input logic [31:0] raw);
        case (op)
            OP_LB:   load_extend = {{24{raw[7]}}, raw[7:0]};
            OP_LBU:  load_extend = {24'd0, raw[7:0]};
            OP_LH:   load_extend = {{16{raw[15]}}, raw[15:0]};
            OP_LHU:  load_extend = {16'd0, raw[15:0]};
            default: load_extend = raw;
        endcase
    endfunction

    function automatic logic [7:0] store_byte(input logic [31:0] data, input logic [1:0] idx);
        case (idx)
            2'd0:    store_byte = data[7:0];
            2'd1:    store_byte = data[15:8];
            2'd2:    store_byte = data[23:16];
            2'd3:    store_byte = data[31:24];
            default: store_byte = 8'd0;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] addr_r;
    logic [31:0] sdata_r;
    logic [31:0] ldata_r;
    logic [4:0]  op_r;
    logic [4:0]  wd_r;
    logic        is_load_r;
    logic        misalign_r;
    logic [2:0]  k_r;
    logic [2:0]  n_r;

    logic        is_load_s;
    logic        mem_op_s;
    logic        misalign_s;
    logic [2:0]  k_inc_s;
    logic        last_byte_s;

    assign is_load_s   = (opcode_i == OPC_LOAD);
    assign mem_op_s    = is_load_s || (opcode_i == OPC_SAVE);
    assign k_inc_s     = k_r + 3'd1;
    assign last_byte_s = (k_inc_s >= n_r);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = ((byte_count(op_i) == 3'd2) && mem_addr_i[0]) ||
                        ((byte_count(op_i) == 3'd4) && (mem_addr_i[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // access context: captured on entry, byte index and load buffer advance per completed byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r     <= 32'd0;
            sdata_r    <= 32'd0;
            ldata_r    <= 32'd0;
            op_r       <= 5'd0;
            wd_r       <= 5'd0;
            is_load_r  <= 1'b0;
            misalign_r <= 1'b0;
            k_r        <= 3'd0;
            n_r        <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        addr_r     <= mem_addr_i;
                        sdata_r    <= wdata_i;
                        ldata_r    <= 32'd0;
                        op_r       <= op_i;
                        wd_r       <= wd_i;
                        is_load_r  <= is_load_s;
                        misalign_r <= misalign_s;
                        k_r        <= 3'd0;
                        n_r        <= byte_count(op_i);
                    end
                end
                REQ: begin
                    // reads complete in WAIT; writes complete on the grant itself
                    if (mem_gnt_i && !is_load_r) begin
                        k_r <= k_inc_s;
                    end
                end
                WAIT: begin
                    ldata_r[{k_r[1:0], 3'b000} +: 8] <= mem_din_i;
                    k_r <= k_inc_s;
                end
                default: begin
                    k_r <= k_r;
                end
            endcase
        end
    end

    // next state and all outputs; reset forces outputs low without waiting for a clock
    always_comb begin
        state_next_s = state_r;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_a_o      = 32'd0;
        mem_dout_o   = 8'd0;
        wd_o         = 5'd0;
        wreg_o       = 1'b0;
        wdata_o      = 32'd0;
        stall_req_o  = 1'b0;
        err_o        = 1'b0;
        if (!rst) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        stall_req_o = 1'b1;
                        if (misalign_s) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = REQ;
                        end
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                REQ: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = !is_load_r;
                    mem_a_o     = addr_r + {29'd0, k_r};
                    mem_dout_o  = store_byte(sdata_r, k_r[1:0]);
                    if (mem_gnt_i) begin
                        if (is_load_r) begin
                            state_next_s = WAIT;
                        end else if (last_byte_s) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = REQ;
                        end
                    end else begin
                        state_next_s = REQ;
                    end
                end
                WAIT: begin
                    stall_req_o = 1'b1;
                    if (last_byte_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = REQ;
                    end
                end
                DONE: begin
                    state_next_s = IDLE;
                    wd_o         = wd_r;
                    err_o        = misalign_r;
                    if (is_load_r && !misalign_r) begin
                        wreg_o  = 1'b1;
                        wdata_o = load_extend(op_r, ldata_r);
                    end else begin
                        wreg_o  = 1'b0;
                        wdata_o = 32'd0;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

endmodule
